// File: rtl/muldiv_if.sv
// muldiv_if: request/response handshake bundle for muldiv_unit.
// master = pipeline (EX stage), slave = the multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, op, op1, op2, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, op, op1, op2, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one result bit per cycle, one op in flight.
// Define MULDIV_FAST_MUL_EN to make all multiplies a single combinational step.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave io
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;

  logic [2:0]       op_r;
  logic [XLEN-1:0]  a_r, hi_r, lo_r, res_r;
  logic             neg_r;
  logic [CNT_W-1:0] cnt_r;

  logic            acc, is_div, s1, s2, neg, dz, ovf, early, last;
  logic [XLEN-1:0] m1, m2, spec_res, early_res;

  // Accept-side decode: operand signedness, magnitudes and the one-cycle special cases
  always_comb begin
    acc    = io.in_valid && (state == IDLE) && !io.flush;
    is_div = io.op[2];
    s1     = io.op1[XLEN-1] && (io.op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
    s2     = io.op2[XLEN-1] && (io.op inside {3'd0, 3'd1, 3'd4, 3'd6});
    neg    = (io.op == 3'd6) ? s1 : (s1 ^ s2);
    m1     = s1 ? -io.op1 : io.op1;
    m2     = s2 ? -io.op2 : io.op2;
    dz     = is_div && (io.op2 == '0);
    ovf    = is_div && !io.op[0] && (io.op1 == MIN_NEG) && (io.op2 == '1);
    if (dz) spec_res = io.op[1] ? io.op1 : '1;
    else    spec_res = io.op[1] ? '0 : io.op1;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fprod;
  assign fprod     = {{XLEN{s1}}, io.op1} * {{XLEN{s2}}, io.op2};
  assign early     = dz || ovf || !is_div;
  assign early_res = (dz || ovf)         ? spec_res :
                     (io.op[1:0] == 2'd0) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
  assign early     = dz || ovf;
  assign early_res = spec_res;
`endif

  // One iteration: shift-add multiply on {hi,lo}, restoring divide with hi=remainder, lo=quotient
  logic [XLEN:0]     madd, rsh, diff;
  logic [XLEN-1:0]   mhi, mlo, dhi, dlo, dval, fin_res;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    madd = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : '0);
    mhi  = madd[XLEN:1];
    mlo  = {madd[0], lo_r[XLEN-1:1]};
    rsh  = {hi_r, lo_r[XLEN-1]};
    diff = rsh - {1'b0, a_r};
    dhi  = diff[XLEN] ? rsh[XLEN-1:0] : diff[XLEN-1:0];
    dlo  = {lo_r[XLEN-2:0], ~diff[XLEN]};
    prod = neg_r ? -{mhi, mlo} : {mhi, mlo};
    dval = op_r[1] ? dhi : dlo;
    if (op_r[2])                fin_res = neg_r ? -dval : dval;
    else if (op_r[1:0] == 2'd0) fin_res = prod[XLEN-1:0];
    else                        fin_res = prod[2*XLEN-1:XLEN];
  end

  assign last = (state == CALC) && (cnt_r == CNT_W'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (acc) state_n = early ? DONE : CALC;
      CALC:    if (last) state_n = DONE;
      DONE:    if (io.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (io.flush) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r  <= '0;
      a_r   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      res_r <= '0;
      neg_r <= 1'b0;
      cnt_r <= '0;
    end else if (!io.flush) begin
      if (acc) begin
        op_r  <= io.op;
        neg_r <= neg;
        cnt_r <= '0;
        hi_r  <= '0;
        a_r   <= is_div ? m2 : m1;
        lo_r  <= is_div ? m1 : m2;
        if (early) res_r <= early_res;
      end else if (state == CALC) begin
        hi_r <= op_r[2] ? dhi : mhi;
        lo_r <= op_r[2] ? dlo : mlo;
        if (last) res_r <= fin_res;
        else      cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.busy      = (state != IDLE);
  assign io.result    = res_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table for muldiv_unit plus handshake, flush and reset sequences.
module tb_muldiv_unit;
  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN)) bus();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .io(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, bus.out_valid, bus.in_ready, bus.busy};
  endfunction

  // Issue one op, measure latency in edges (accept edge = 1), optionally stall the consumer
  task automatic run_op(input vec_t v, input int hold);
    int lat;
    @(negedge clk);
    check({v.name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op       = v.op;
    bus.op1      = v.a;
    bus.op2      = v.b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op1      = ~v.a;
    bus.op2      = ~v.b;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({v.name, "_lat"}, 32'(lat), 32'(v.lat));
    check({v.name, "_res"}, bus.result, v.exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({v.name, "_hold_res"}, bus.result, v.exp);
      check({v.name, "_hold_flags"}, flags(), 32'b101);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    check({v.name, "_hs_in_ready"}, 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({v.name, "_release"}, flags(), 32'b010);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = 3'd0; bus.op1 = '0; bus.op2 = '0;

    vecs.push_back('{3'd0, 32'd7,         32'd6,         32'h0000002A, MUL_LAT, "mul_7x6"});
    vecs.push_back('{3'd0, 32'hFFFFFFFD,  32'd5,         32'hFFFFFFF1, MUL_LAT, "mul_neg"});
    vecs.push_back('{3'd1, 32'hFFFFFFFD,  32'd5,         32'hFFFFFFFF, MUL_LAT, "mulh_neg"});
    vecs.push_back('{3'd1, 32'h80000000,  32'h80000000,  32'h40000000, MUL_LAT, "mulh_min"});
    vecs.push_back('{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, MUL_LAT, "mulhu_max"});
    vecs.push_back('{3'd2, 32'hFFFFFFFF,  32'h00000002,  32'hFFFFFFFF, MUL_LAT, "mulhsu_m1x2"});
    vecs.push_back('{3'd2, 32'h80000000,  32'h80000000,  32'hC0000000, MUL_LAT, "mulhsu_min"});
    vecs.push_back('{3'd4, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD, DIV_LAT, "div_m7_2"});
    vecs.push_back('{3'd6, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF, DIV_LAT, "rem_m7_2"});
    vecs.push_back('{3'd5, 32'd100,       32'd7,         32'd14,       DIV_LAT, "divu_100_7"});
    vecs.push_back('{3'd7, 32'd100,       32'd7,         32'd2,        DIV_LAT, "remu_100_7"});
    vecs.push_back('{3'd4, 32'd20,        32'hFFFFFFFD,  32'hFFFFFFFA, DIV_LAT, "div_20_m3"});
    vecs.push_back('{3'd6, 32'd20,        32'hFFFFFFFD,  32'd2,        DIV_LAT, "rem_20_m3"});
    vecs.push_back('{3'd4, 32'h80000000,  32'd3,         32'hD5555556, DIV_LAT, "div_min_3"});
    vecs.push_back('{3'd6, 32'h80000000,  32'd3,         32'hFFFFFFFE, DIV_LAT, "rem_min_3"});
    vecs.push_back('{3'd5, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF, DIV_LAT, "divu_max_1"});
    vecs.push_back('{3'd5, 32'd5,         32'd0,         32'hFFFFFFFF, 1,       "divu_by0"});
    vecs.push_back('{3'd6, 32'd5,         32'd0,         32'd5,        1,       "rem_by0"});
    vecs.push_back('{3'd4, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 1,       "div_ovf"});
    vecs.push_back('{3'd6, 32'h80000000,  32'hFFFFFFFF,  32'd0,        1,       "rem_ovf"});

    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", flags(), 32'b010);
    check("reset_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i], 0);

    // Consumer stalls for 10 cycles after out_valid
    run_op(vecs[0], 10);

    // Flush during cycle 10 of a divide
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 3'd4; bus.op1 = 32'd1000; bus.op2 = 32'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("calc_flags", flags(), 32'b001);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_flags", flags(), 32'b010);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("flush_no_valid", 32'(seen), 32'd0);

    // flush alongside in_valid: nothing is accepted
    @(negedge clk);
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.op = 3'd5; bus.op1 = 32'd9; bus.op2 = 32'd0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("flush_accept_flags", flags(), 32'b010);
    check("flush_accept_result", bus.result, 32'h0000002A);

    // Synchronous reset in the middle of a divide
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 3'd5; bus.op1 = 32'd12345; bus.op2 = 32'd11;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_flags", flags(), 32'b010);
    check("rst_mid_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(vecs[9], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
